nios_ii_system_led_pio: RTL and testbench

Parametrised Avalon-MM output PIO for the NIOS II system, successor to the fixed 8-bit LED output port. Adds configurable width and reset value, atomic bit set/clear registers, and a per-bit hardware blink engine driven by a programmable prescaler. Sits on the system interconnect as a zero-wait-state slave and drives board LEDs or other level outputs directly.

---
 rtl/nios_ii_system_led_pio.sv | 148 ++++++++++++++
 tb/tb_nios_ii_system_led_pio.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nios_ii_system_led_pio.sv
// nios_ii_system_led_pio
// Avalon-MM output PIO with a zero-wait-state slave port. It provides:
//   - a DATA register
//   - atomic bit set (OUTSET) and bit clear (OUTCLEAR) registers
//   - an optional per-bit blink engine, compiled in when LED_PIO_BLINK_EN
//     is defined
// In the default build (macro undefined) the blink registers are absent:
//   - addresses 1..3 read 0 and ignore writes
//   - out_port follows DATA directly
module nios_ii_system_led_pio #(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic             wr_en;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] data_q, data_d;

  assign wr_en   = chipselect & ~write_n;
  assign wdata_w = writedata[WIDTH-1:0];

  // DATA next-state: direct load, atomic OR-set, or atomic AND-NOT-clear.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d = wdata_w;
        ADDR_OUTSET:   data_d = data_q | wdata_w;
        ADDR_OUTCLEAR: data_d = data_q & ~wdata_w;
        default:       data_d = data_q;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                period_wr;

  // Bits of writedata above PERIOD_W are deliberately ignored.
  logic wdata_unused;
  assign wdata_unused = ^writedata;

  assign period_wr = wr_en && (address == ADDR_PERIOD);

  // Blink engine next-state.
  // A period write restarts the half-period even if the counter is at
  // terminal count, so shrinking the period can never strand cnt above it.
  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = wdata_w;
    end
    if (period_wr) begin
      period_d = writedata[PERIOD_W-1:0];
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // Register state with synchronous active-low reset; reset discards any
  // write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Masked bits are forced low during phase 0.
  assign out_port = data_q & ~(mask_q & {WIDTH{~phase_q}});

  // Combinational read mux; unused upper bits and write-only registers read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]    = data_q;
      ADDR_MASK:   readdata[WIDTH-1:0]    = mask_q;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: readdata[0]            = phase_q;
      default:     readdata               = '0;
    endcase
  end
`else
  // Bits of writedata above WIDTH are deliberately ignored.
  logic wdata_unused;
  assign wdata_unused = ^writedata;

  // DATA register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign out_port = data_q;

  // Combinational read mux; only DATA is readable in this build.
  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) begin
      readdata[WIDTH-1:0] = data_q;
    end
  end
`endif

endmodule

// File: tb/tb_nios_ii_system_led_pio.sv
// Directed bench for nios_ii_system_led_pio (WIDTH=8, RESET_VALUE=8'hA5).
// Blink checks are compiled only when LED_PIO_BLINK_EN is defined, matching the DUT build.
module tb_nios_ii_system_led_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks;
  int errors;
  logic [31:0] rdv;

  nios_ii_system_led_pio #(
    .WIDTH(8),
    .PERIOD_W(24),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a write from the falling edge; it is sampled on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Combinational read within the current cycle.
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    chk("rst_out", {24'h0, out_port}, 32'h0000_00A5);
    rd(3'd0, rdv); chk("rst_data", rdv, 32'h0000_00A5);
`ifdef LED_PIO_BLINK_EN
    rd(3'd3, rdv); chk("rst_status", rdv, 32'h0000_0001);
    rd(3'd1, rdv); chk("rst_mask", rdv, 32'h0);
    rd(3'd2, rdv); chk("rst_period", rdv, 32'h0);
`else
    rd(3'd3, rdv); chk("rst_status", rdv, 32'h0);
`endif

    // DATA write; out_port must still be old during the write cycle
    @(negedge clk);
    address = 3'd0; writedata = 32'hFFFF_FF3C; chipselect = 1'b1; write_n = 1'b0;
    #1;
    chk("lag_before", {24'h0, out_port}, 32'h0000_00A5);
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    chk("data_out", {24'h0, out_port}, 32'h0000_003C);
    rd(3'd0, rdv); chk("data_rd", rdv, 32'h0000_003C);

    // OUTSET / OUTCLEAR
    wr(3'd4, 32'h0000_0001);
    chk("set_out", {24'h0, out_port}, 32'h0000_003D);
    rd(3'd0, rdv); chk("set_rd", rdv, 32'h0000_003D);
    rd(3'd4, rdv); chk("outset_rd0", rdv, 32'h0);
    wr(3'd5, 32'hFFFF_FF0C);
    chk("clr_out", {24'h0, out_port}, 32'h0000_0031);
    rd(3'd0, rdv); chk("clr_rd", rdv, 32'h0000_0031);
    rd(3'd5, rdv); chk("outclr_rd0", rdv, 32'h0);

    // Reserved addresses and read-only STATUS
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'h0000_0000);
    wr(3'd3, 32'h0000_0000);
    rd(3'd0, rdv); chk("rsvd_nowrite", rdv, 32'h0000_0031);
    rd(3'd6, rdv); chk("rsvd6_rd", rdv, 32'h0);
    rd(3'd7, rdv); chk("rsvd7_rd", rdv, 32'h0);

`ifdef LED_PIO_BLINK_EN
    rd(3'd3, rdv); chk("status_ro", rdv, 32'h1);

    // Blink: DATA=FF, MASK=0F, PERIOD=3 -> 4 cycles FF, 4 cycles F0
    wr(3'd0, 32'h0000_00FF);
    wr(3'd1, 32'h0000_000F);
    wr(3'd2, 32'h0000_0003);
    rd(3'd1, rdv); chk("mask_rd", rdv, 32'h0000_000F);
    rd(3'd2, rdv); chk("period_rd", rdv, 32'h0000_0003);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("blink_out_%0d", k), {24'h0, out_port},
          (((k / 4) % 2) == 0) ? 32'h0000_00FF : 32'h0000_00F0);
      rd(3'd3, rdv);
      chk($sformatf("blink_stat_%0d", k), rdv,
          (((k / 4) % 2) == 0) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
    end
    // Now at k=16: cnt=0, phase 1. Advance to k=19 where cnt==3.
    repeat (3) @(posedge clk);
    #1;
    chk("pre_tc_out", {24'h0, out_port}, 32'h0000_00FF);
    // Period write at terminal count: no toggle, restart phase 1
    wr(3'd2, 32'h0000_0003);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("tc_out_%0d", j), {24'h0, out_port},
          (j < 4) ? 32'h0000_00FF : 32'h0000_00F0);
      @(posedge clk);
      #1;
    end

    // Reset during blink with a simultaneous DATA write
    @(negedge clk);
    reset_n = 1'b0;
    address = 3'd0; writedata = 32'h0000_0012; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    chk("rst2_out", {24'h0, out_port}, 32'h0000_00A5);
    rd(3'd0, rdv); chk("rst2_data", rdv, 32'h0000_00A5);
    rd(3'd1, rdv); chk("rst2_mask", rdv, 32'h0);
    rd(3'd2, rdv); chk("rst2_period", rdv, 32'h0);
    rd(3'd3, rdv); chk("rst2_status", rdv, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("rst2_out_hold", {24'h0, out_port}, 32'h0000_00A5);
`else
    // No blink engine: addresses 1..3 are inert
    wr(3'd1, 32'h0000_00FF);
    wr(3'd2, 32'h0000_0005);
    rd(3'd1, rdv); chk("nb_mask_rd", rdv, 32'h0);
    rd(3'd2, rdv); chk("nb_period_rd", rdv, 32'h0);
    rd(3'd3, rdv); chk("nb_status_rd", rdv, 32'h0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("nb_out_%0d", j), {24'h0, out_port}, 32'h0000_0031);
      @(posedge clk);
      #1;
    end
    // Reset with a simultaneous DATA write: write is lost
    @(negedge clk);
    reset_n = 1'b0;
    address = 3'd0; writedata = 32'h0000_0012; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    chk("nb_rst_out", {24'h0, out_port}, 32'h0000_00A5);
    rd(3'd0, rdv); chk("nb_rst_data", rdv, 32'h0000_00A5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
